// File: rtl/mvm_stream_tx_pkg.sv
// Shared definitions for the MVM transmit stream: default geometry,
// derived job length and the TX state encoding.
package mvm_stream_tx_pkg;

   localparam int NROWS_A_DEF = 4;
   localparam int DATA_W_DEF  = 8;

   // A (N*N) followed by X (N) and B (N)
   function automatic int job_len(input int nrows);
      return nrows * nrows + 2 * nrows;
   endfunction

   localparam int JOB_LEN_DEF = job_len(NROWS_A_DEF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } tx_state_t;

endpackage

// File: rtl/mvm_stream_tx_if.sv
// Valid/ready byte stream toward the MVM s_valid/s_ready/data_in port.
interface mvm_stream_tx_if #(parameter int DATA_W = 8);
   logic                     m_valid;
   logic                     m_ready;
   logic signed [DATA_W-1:0] data_out;

   modport master (output m_valid, output data_out, input m_ready);
   modport slave  (input m_valid, input data_out, output m_ready);
endinterface

// File: rtl/memory.sv
// Simple dual-port RAM: one write port, one synchronous read port
// (read data appears one cycle after i_re and holds otherwise).
module memory #(
   parameter int WIDTH   = 8,
   parameter int SIZE    = 24,
   parameter int LOGSIZE = 5
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [LOGSIZE-1:0] i_waddr,
   input  logic [WIDTH-1:0]   i_wdata,
   input  logic               i_re,
   input  logic [LOGSIZE-1:0] i_raddr,
   output logic [WIDTH-1:0]   o_rdata
);

   logic [WIDTH-1:0] r_mem [SIZE];

   // Write port and registered read port
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/mvm_tx_skid.sv
// Output register plus one-entry skid buffer. The output register holds
// the byte on the bus; the skid catches the prefetched byte that returns
// from memory while the consumer stalls, so no read is ever lost.
module mvm_tx_skid #(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_first,   // load first byte of a job
   input  logic                     i_pf_vld,  // i_data carries a prefetch this cycle
   input  logic                     i_last,    // byte on the bus is the last of the job
   input  logic                     i_ready,
   input  logic signed [DATA_W-1:0] i_data,
   output logic                     o_valid,
   output logic signed [DATA_W-1:0] o_data
);

   logic                     r_out_vld;
   logic signed [DATA_W-1:0] r_out_data;
   logic                     r_skid_vld;
   logic signed [DATA_W-1:0] r_skid_data;
   logic                     w_hs;

   assign w_hs    = r_out_vld & i_ready;
   assign o_valid = r_out_vld;
   assign o_data  = r_out_data;

   // Output register and skid occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_skid_vld <= 1'b0;
      end else if (i_first) begin
         r_out_vld  <= 1'b1;
         r_out_data <= i_data;
         r_skid_vld <= 1'b0;
      end else if (w_hs) begin
         r_skid_vld <= 1'b0;
         if (i_last) r_out_vld <= 1'b0;
         else        r_out_data <= r_skid_vld ? r_skid_data : i_data;
      end else if (i_pf_vld) begin
         r_skid_vld <= 1'b1;
      end
   end

   // Skid data capture on a stalled prefetch return
   always_ff @(posedge clk) begin
      if (!i_first && !w_hs && i_pf_vld) r_skid_data <= i_data;
   end

endmodule

// File: rtl/mvm_stream_tx.sv
// Ping-pong job buffer and byte streamer feeding the MVM input port.
// The host loads one buffer while the other drains in commit order.
// Optional build macro MVM_TX_STATS_EN adds saturating stall_cnt/job_cnt.
module mvm_stream_tx
   import mvm_stream_tx_pkg::*;
#(
   parameter  int NROWS_A = NROWS_A_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   localparam int JOB_LEN = job_len(NROWS_A),
   localparam int AW      = $clog2(JOB_LEN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     commit,
   output logic                     load_ready,
   output logic                     commit_err,
   mvm_stream_tx_if.master          tx,
   output logic                     job_done,
   output logic                     busy
`ifdef MVM_TX_STATS_EN
   ,
   output logic [15:0]              stall_cnt,
   output logic [15:0]              job_cnt
`endif
);

   localparam logic [AW:0] LAST_EXT = (AW+1)'(JOB_LEN - 1);
   localparam logic [AW:0] LEN_EXT  = (AW+1)'(JOB_LEN);

   tx_state_t r_state, w_state_nxt;
   logic [1:0]    r_full;
   logic          r_wr_sel, r_rd_sel, r_commit_err;
   logic [AW-1:0] r_idx;
   logic          r_pf_vld_p1;

   logic          w_load_ready, w_wr_ok, w_commit_ok;
   logic [1:0]    w_we;
   logic          w_ren, w_first, w_issue_pf, w_done, w_hs, w_last;
   logic [AW-1:0] w_raddr;
   logic [AW:0]   w_idx_p2;
   logic signed [DATA_W-1:0] w_rdata0, w_rdata1, w_rdata;
   logic          w_valid;
   logic signed [DATA_W-1:0] w_data;

   assign w_load_ready = !r_full[r_wr_sel];
   assign w_wr_ok      = wr_en & w_load_ready & ({1'b0, wr_addr} < LEN_EXT);
   assign w_commit_ok  = commit & w_load_ready;
   assign w_we[0]      = w_wr_ok & (r_wr_sel == 1'b0);
   assign w_we[1]      = w_wr_ok & (r_wr_sel == 1'b1);
   assign w_rdata      = r_rd_sel ? w_rdata1 : w_rdata0;
   assign w_hs         = w_valid & tx.m_ready;
   assign w_last       = (r_idx == AW'(JOB_LEN - 1));
   assign w_idx_p2     = {1'b0, r_idx} + (AW+1)'(2);

   memory #(.WIDTH(DATA_W), .SIZE(JOB_LEN), .LOGSIZE(AW)) u_buf0 (
      .clk     (clk),
      .i_we    (w_we[0]),
      .i_waddr (wr_addr),
      .i_wdata (wr_data),
      .i_re    (w_ren),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata0)
   );

   memory #(.WIDTH(DATA_W), .SIZE(JOB_LEN), .LOGSIZE(AW)) u_buf1 (
      .clk     (clk),
      .i_we    (w_we[1]),
      .i_waddr (wr_addr),
      .i_wdata (wr_data),
      .i_re    (w_ren),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata1)
   );

   mvm_tx_skid #(.DATA_W(DATA_W)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .i_first  (w_first),
      .i_pf_vld (r_pf_vld_p1),
      .i_last   (w_last),
      .i_ready  (tx.m_ready),
      .i_data   (w_rdata),
      .o_valid  (w_valid),
      .o_data   (w_data)
   );

   // Buffer ownership: commit fills the load side, job completion frees the TX side.
   // The two never touch the same buffer in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full       <= 2'b00;
         r_wr_sel     <= 1'b0;
         r_rd_sel     <= 1'b0;
         r_commit_err <= 1'b0;
      end else begin
         if (w_commit_ok) begin
            r_full[r_wr_sel] <= 1'b1;
            r_wr_sel         <= ~r_wr_sel;
         end
         if (w_done) begin
            r_full[r_rd_sel] <= 1'b0;
            r_rd_sel         <= ~r_rd_sel;
         end
         if ((wr_en | commit) & !w_load_ready) r_commit_err <= 1'b1;
      end
   end

   // TX state register, byte index and prefetch-return flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_pf_vld_p1 <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pf_vld_p1 <= w_issue_pf;
         if (w_first)            r_idx <= '0;
         else if (w_hs & !w_last) r_idx <= r_idx + AW'(1);
      end
   end

   // TX next-state and read issue: one prefetch is kept in flight ahead of the bus byte
   always_comb begin
      w_state_nxt = r_state;
      w_ren       = 1'b0;
      w_raddr     = '0;
      w_first     = 1'b0;
      w_issue_pf  = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_full[r_rd_sel]) begin
               w_ren       = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            w_first     = 1'b1;
            w_ren       = 1'b1;
            w_raddr     = AW'(1);
            w_issue_pf  = 1'b1;
            w_state_nxt = STREAM;
         end
         STREAM: begin
            if (w_hs) begin
               if (w_last) begin
                  w_done = 1'b1;
                  if (r_full[~r_rd_sel]) begin
                     w_ren       = 1'b1;
                     w_state_nxt = FETCH;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else if (w_idx_p2 <= LAST_EXT) begin
                  w_ren      = 1'b1;
                  w_raddr    = w_idx_p2[AW-1:0];
                  w_issue_pf = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign tx.m_valid  = w_valid;
   assign tx.data_out = w_data;
   assign load_ready  = w_load_ready;
   assign commit_err  = r_commit_err;
   assign job_done    = w_done;
   assign busy        = (r_state != IDLE);

`ifdef MVM_TX_STATS_EN
   logic [15:0] r_stall_cnt, r_job_cnt;

   // Saturating stall-cycle and completed-job counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_job_cnt   <= '0;
      end else begin
         if (w_valid && !tx.m_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_done && r_job_cnt != 16'hFFFF)
            r_job_cnt <= r_job_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign job_cnt   = r_job_cnt;
`endif

endmodule

// File: tb/tb_mvm_stream_tx.sv
// Directed bench for mvm_stream_tx: table of single-job streams with
// different ready patterns, then back-to-back, overflow and reset sequences.
module tb_mvm_stream_tx;

   localparam int JL = 24;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic [4:0]        wr_addr = '0;
   logic signed [7:0] wr_data = '0;
   logic              commit = 1'b0;
   logic              load_ready, commit_err, job_done, busy;
`ifdef MVM_TX_STATS_EN
   logic [15:0]       stall_cnt, job_cnt;
`endif

   mvm_stream_tx_if #(.DATA_W(8)) bus ();

   mvm_stream_tx dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .commit     (commit),
      .load_ready (load_ready),
      .commit_err (commit_err),
      .tx         (bus),
      .job_done   (job_done),
      .busy       (busy)
`ifdef MVM_TX_STATS_EN
      ,
      .stall_cnt  (stall_cnt),
      .job_cnt    (job_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic signed [7:0] g_job [JL];
   logic signed [7:0] g_exp [64];
   int                g_acc_k [64];

   typedef struct {
      logic [3:0]        pat;         // m_ready pattern, leftmost bit first
      logic signed [7:0] b0, b1, b2;  // bytes 0..2; bytes 3..23 are i+1
      int                exp_cycles;  // cycles from first valid to last accept
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic load_job();
      for (int i = 0; i < JL; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = 5'(i);
         wr_data = g_job[i];
      end
      @(negedge clk);
      wr_en  = 1'b0;
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   // Drives m_ready from the pattern once valid appears and checks each
   // accepted byte, held data during stalls and job_done on every cycle.
   task automatic run_stream(input logic [3:0] pat, input int nexp, input int budget,
                             output int nacc, output int ndone, output int last_k);
      int k;
      logic started, prev_stall, hs, exp_done;
      logic signed [7:0] prev_data;
      nacc = 0; ndone = 0; last_k = -1; k = 0;
      started = 1'b0; prev_stall = 1'b0; prev_data = '0;
      for (int c = 0; c < budget && nacc < nexp; c++) begin
         @(negedge clk);
         if (prev_stall) begin
            chk("hold_valid", int'(bus.m_valid), 1);
            chk("hold_data", int'(bus.data_out), int'(prev_data));
         end
         if (bus.m_valid) started = 1'b1;
         bus.m_ready = started ? pat[3 - (k % 4)] : 1'b0;
         #1;
         hs = bus.m_valid & bus.m_ready;
         if (hs) begin
            chk("data", int'(bus.data_out), int'(g_exp[nacc]));
            g_acc_k[nacc] = k;
            last_k = k;
            nacc++;
         end
         exp_done = hs && (nacc % JL == 0);
         chk("job_done", int'(job_done), int'(exp_done));
         if (job_done) ndone++;
         prev_stall = bus.m_valid & !bus.m_ready;
         prev_data  = bus.data_out;
         if (started) k++;
      end
      if (nacc < nexp) chk("stream_timeout", nacc, nexp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc, ndone, last_k, vcnt;
      bus.m_ready = 1'b0;

      vecs[0] = '{4'b1111, 8'sh01, 8'sh02, 8'sh03, 24};
      vecs[1] = '{4'b1001, 8'sh01, 8'sh02, 8'sh03, 48};
      vecs[2] = '{4'b0111, 8'sh80, 8'sh7F, 8'shFF, 32};
      vecs[3] = '{4'b1010, 8'sh55, 8'shFE, 8'sh00, 47};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_m_valid",    int'(bus.m_valid), 0);
      chk("rst_data_out",   int'(bus.data_out), 0);
      chk("rst_job_done",   int'(job_done), 0);
      chk("rst_busy",       int'(busy), 0);
      chk("rst_commit_err", int'(commit_err), 0);
      chk("rst_load_ready", int'(load_ready), 1);
      reset = 1'b0;

      // Table-driven single jobs
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < JL; i++) begin
            g_job[i] = (i == 0) ? vecs[v].b0 : (i == 1) ? vecs[v].b1 :
                       (i == 2) ? vecs[v].b2 : 8'(i + 1);
            g_exp[i] = g_job[i];
         end
         bus.m_ready = 1'b0;
         load_job();
         run_stream(vecs[v].pat, JL, 400, nacc, ndone, last_k);
         chk("vec_cycles", last_k + 1, vecs[v].exp_cycles);
         chk("vec_done_count", ndone, 1);
         @(negedge clk);
         chk("vec_after_valid", int'(bus.m_valid), 0);
         chk("vec_after_busy", int'(busy), 0);
         chk("vec_after_load_ready", int'(load_ready), 1);
      end

      // Back-to-back jobs with both buffers full, plus a rejected third job
      bus.m_ready = 1'b0;
      for (int i = 0; i < JL; i++) begin
         g_job[i] = 8'(32'h10 + i);
         g_exp[i] = g_job[i];
      end
      load_job();
      for (int i = 0; i < JL; i++) begin
         g_job[i] = 8'(32'h80 + i);
         g_exp[JL + i] = g_job[i];
      end
      load_job();
      chk("both_full_load_ready", int'(load_ready), 0);
      chk("both_full_no_err", int'(commit_err), 0);
      for (int i = 0; i < JL; i++) g_job[i] = 8'(32'h40 + i);
      load_job();
      chk("third_commit_err", int'(commit_err), 1);
      chk("third_load_ready", int'(load_ready), 0);
      run_stream(4'b1111, 2 * JL, 300, nacc, ndone, last_k);
      chk("b2b_done_count", ndone, 2);
      chk("b2b_gap", g_acc_k[JL] - g_acc_k[JL - 1], 2);
      chk("b2b_last_k", last_k, 2 * JL);
      vcnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.m_valid) vcnt++;
      end
      chk("third_job_absent", vcnt, 0);
      chk("b2b_busy", int'(busy), 0);
      chk("b2b_load_ready", int'(load_ready), 1);
      chk("b2b_err_sticky", int'(commit_err), 1);

      // Reset clears the sticky error; out-of-range write is silently dropped
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("rst2_commit_err", int'(commit_err), 0);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd24; wr_data = 8'sh77;
      @(negedge clk);
      wr_en = 1'b0;
      chk("oob_write_no_err", int'(commit_err), 0);

      // Reset in the middle of a stream
      bus.m_ready = 1'b0;
      for (int i = 0; i < JL; i++) begin
         g_job[i] = 8'(i + 1);
         g_exp[i] = g_job[i];
      end
      load_job();
      run_stream(4'b1111, 10, 100, nacc, ndone, last_k);
      chk("mid_accepted", nacc, 10);
      @(negedge clk);
      chk("mid_byte10_valid", int'(bus.m_valid), 1);
      chk("mid_byte10_data", int'(bus.data_out), 11);
      reset = 1'b1;
      bus.m_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_valid", int'(bus.m_valid), 0);
      chk("mid_rst_load_ready", int'(load_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);

      // Fresh job after the abort starts at byte 0
      for (int i = 0; i < JL; i++) begin
         g_job[i] = 8'(32'h30 + i);
         g_exp[i] = g_job[i];
      end
      load_job();
      run_stream(4'b1111, JL, 200, nacc, ndone, last_k);
      chk("fresh_done_count", ndone, 1);
      chk("fresh_cycles", last_k + 1, JL);
      @(negedge clk);
      chk("fresh_after_valid", int'(bus.m_valid), 0);
      chk("fresh_after_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
